// File: rtl/rom_dma_batch_sched.sv
// Batch scheduler: pops host-loaded DMA descriptors and sequences the ROM DMA
// controller through LOAD/RUN/DRAIN/GAP for each one, with a run watchdog.
module rom_dma_batch_sched #(
  parameter int ROM_ADDR_WIDTH = 12,
  parameter int DESC_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              desc_push,
  input  logic [ROM_ADDR_WIDTH-1:0]         desc_base_addr,
  input  logic [ROM_ADDR_WIDTH-1:0]         desc_num_bytes,
  output logic                              desc_full,
  output logic [$clog2(DESC_DEPTH+1)-1:0]   desc_count,
  input  logic                              sched_enable,
  output logic                              start_rd,
  output logic                              cfg_ready,
  output logic [ROM_ADDR_WIDTH-1:0]         cfg_dma_base_addr,
  output logic [ROM_ADDR_WIDTH-1:0]         cfg_dma_num_bytes,
  input  logic                              batch_dma_done,
  input  logic                              ll_idle,
  input  logic                              clear_err,
  output logic                              busy,
  output logic                              job_done,
  output logic                              job_err,
  output logic                              err_timeout,
  output logic                              err_zero_len,
  output logic                              err_overflow,
  output logic [15:0]                       jobs_completed
);

  localparam int PTR_W = $clog2(DESC_DEPTH);
  localparam int CNT_W = $clog2(DESC_DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t state, state_nxt;

  logic [ROM_ADDR_WIDTH-1:0] mem_base [DESC_DEPTH];
  logic [ROM_ADDR_WIDTH-1:0] mem_num  [DESC_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count_nxt;
  logic [ROM_ADDR_WIDTH-1:0] head_base, head_num;
  logic [WD_W-1:0]           wdog;
  logic [GAP_W-1:0]          gap_cnt;
  logic                      push_ok, pop, wd_hit, gap_hit;
  logic                      launch, zero_skip, done_evt, to_evt;

  // Handshakes: desc_push is a valid qualified by !desc_full (ready) at the
  // same edge; start_rd/cfg_ready are held as levels for the whole RUN phase
  // and batch_dma_done is the controller's reply, only honoured in RUN.
  assign push_ok   = desc_push && !desc_full;
  assign pop       = (state == S_IDLE) && sched_enable && (desc_count != '0);
  assign head_base = mem_base[rd_ptr];
  assign head_num  = mem_num[rd_ptr];
  assign wd_hit    = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign gap_hit   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  assign start_rd  = (state == S_RUN);
  assign cfg_ready = (state == S_RUN);
  assign busy      = (state != S_IDLE);

  always_comb begin
    count_nxt = desc_count;
    if (push_ok && !pop)
      count_nxt = desc_count + CNT_W'(1);
    else if (pop && !push_ok)
      count_nxt = desc_count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_base[wr_ptr] <= desc_base_addr;
      mem_num[wr_ptr]  <= desc_num_bytes;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      desc_count <= '0;
      desc_full  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      desc_count <= count_nxt;
      desc_full  <= (count_nxt == CNT_W'(DESC_DEPTH));
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    zero_skip = 1'b0;
    done_evt  = 1'b0;
    to_evt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) begin
          if (head_num != '0) begin
            launch    = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            zero_skip = 1'b1;
          end
        end
      end
      S_LOAD: state_nxt = S_RUN;
      S_RUN: begin
        // Completion beats the watchdog when both land on the same cycle.
        if (batch_dma_done) begin
          done_evt  = 1'b1;
          state_nxt = S_DRAIN;
        end else if (wd_hit) begin
          to_evt    = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_DRAIN: if (ll_idle) state_nxt = S_GAP;
      S_GAP:   if (gap_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      wdog              <= '0;
      gap_cnt           <= '0;
      cfg_dma_base_addr <= '0;
      cfg_dma_num_bytes <= '0;
      job_done          <= 1'b0;
      job_err           <= 1'b0;
      jobs_completed    <= '0;
      err_timeout       <= 1'b0;
      err_zero_len      <= 1'b0;
      err_overflow      <= 1'b0;
    end else begin
      state   <= state_nxt;
      wdog    <= (state == S_RUN) ? wdog + WD_W'(1) : '0;
      gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (launch) begin
        cfg_dma_base_addr <= head_base;
        cfg_dma_num_bytes <= head_num;
      end
      job_done <= done_evt;
      job_err  <= to_evt || zero_skip;
      if (done_evt) jobs_completed <= jobs_completed + 16'd1;
      // Sticky errors: a set in the same cycle as clear_err wins.
      err_timeout  <= to_evt ? 1'b1 : (clear_err ? 1'b0 : err_timeout);
      err_zero_len <= zero_skip ? 1'b1 : (clear_err ? 1'b0 : err_zero_len);
      err_overflow <= (desc_push && desc_full) ? 1'b1 :
                      (clear_err ? 1'b0 : err_overflow);
    end
  end

endmodule

// File: tb/tb_rom_dma_batch_sched.sv
// Self-checking bench for rom_dma_batch_sched: a controller responder plus a
// scoreboard of expected launches {base, num, done_after, run_len}.
module tb_rom_dma_batch_sched;

  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int TO    = 48;
  localparam int GAP   = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          desc_push = 1'b0;
  logic [AW-1:0] desc_base_addr = '0;
  logic [AW-1:0] desc_num_bytes = '0;
  logic          desc_full;
  logic [2:0]    desc_count;
  logic          sched_enable = 1'b0;
  logic          start_rd, cfg_ready;
  logic [AW-1:0] cfg_dma_base_addr, cfg_dma_num_bytes;
  logic          batch_dma_done = 1'b0;
  logic          ll_idle = 1'b1;
  logic          clear_err = 1'b0;
  logic          busy, job_done, job_err;
  logic          err_timeout, err_zero_len, err_overflow;
  logic [15:0]   jobs_completed;

  rom_dma_batch_sched #(
    .ROM_ADDR_WIDTH(AW), .DESC_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .desc_push(desc_push), .desc_base_addr(desc_base_addr),
    .desc_num_bytes(desc_num_bytes), .desc_full(desc_full),
    .desc_count(desc_count), .sched_enable(sched_enable),
    .start_rd(start_rd), .cfg_ready(cfg_ready),
    .cfg_dma_base_addr(cfg_dma_base_addr), .cfg_dma_num_bytes(cfg_dma_num_bytes),
    .batch_dma_done(batch_dma_done), .ll_idle(ll_idle), .clear_err(clear_err),
    .busy(busy), .job_done(job_done), .job_err(job_err),
    .err_timeout(err_timeout), .err_zero_len(err_zero_len),
    .err_overflow(err_overflow), .jobs_completed(jobs_completed)
  );

  // scoreboard
  logic [47:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic stray_done = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // controller responder and launch monitor
  logic [47:0]   cur = '0;
  logic          prev_start = 1'b0;
  int            run_cnt = 0;
  logic [AW-1:0] prev_base = '0, prev_num = '0;

  always @(negedge clk) begin
    if (job_done === 1'b1) done_cnt++;
    if (job_err === 1'b1) err_cnt++;
    if (start_rd === 1'b1 && prev_start !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_start", 32'd1, 32'd0);
        cur = '0;
      end else begin
        cur = exp_q.pop_front();
        check_val("load_base", 32'(prev_base), 32'(cur[47:36]));
        check_val("load_num", 32'(prev_num), 32'(cur[35:24]));
        check_val("run_base", 32'(cfg_dma_base_addr), 32'(cur[47:36]));
        check_val("run_num", 32'(cfg_dma_num_bytes), 32'(cur[35:24]));
        check_val("cfg_ready_run", 32'(cfg_ready), 32'd1);
      end
      run_cnt = 1;
    end else if (start_rd === 1'b1) begin
      run_cnt++;
    end else if (prev_start === 1'b1) begin
      if (cur[11:0] != 12'd0) check_val("run_len", 32'(run_cnt), 32'(cur[11:0]));
      check_val("cfg_ready_drop", 32'(cfg_ready), 32'd0);
      run_cnt = 0;
    end
    batch_dma_done = stray_done ||
                     (start_rd === 1'b1 && cur[23:12] != 12'd0 && run_cnt == int'(cur[23:12]));
    prev_start = start_rd;
    prev_base  = cfg_dma_base_addr;
    prev_num   = cfg_dma_num_bytes;
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_desc(input logic [AW-1:0] b, input logic [AW-1:0] n,
                           input int done_after, input int run_len, input bit will_run);
    if (will_run) exp_q.push_back({b, n, 12'(done_after), 12'(run_len)});
    desc_push = 1'b1;
    desc_base_addr = b;
    desc_num_bytes = n;
    @(negedge clk);
    desc_push = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  task automatic wait_jobs(input logic [15:0] n, input string tag);
    int k = 0;
    while (jobs_completed !== n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 32'(jobs_completed), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (start_rd !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, 32'(start_rd), 32'd1);
  endtask

  initial begin
    int n;
    int err_before, done_before;
    logic [AW-1:0] b, nb;
    int da;

    @(negedge clk);
    tick(3);
    // reset state
    check_val("rst_start_rd", 32'(start_rd), 32'd0);
    check_val("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_count", 32'(desc_count), 32'd0);
    check_val("rst_full", 32'(desc_full), 32'd0);
    check_val("rst_jobs", 32'(jobs_completed), 32'd0);
    check_val("rst_errs", 32'({err_timeout, err_zero_len, err_overflow}), 32'd0);
    check_val("rst_pulses", 32'({job_done, job_err}), 32'd0);
    check_val("rst_cfg", 32'({cfg_dma_base_addr, cfg_dma_num_bytes}), 32'd0);
    reset_n = 1'b1;
    tick(1);

    // single job with a slow linked-list drain
    ll_idle = 1'b0;
    push_desc(12'h010, 12'h020, 40, 40, 1'b1);
    sched_enable = 1'b1;
    n = 0;
    while (job_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("single_done_pulse", 32'(job_done), 32'd1);
    check_val("single_jobs", 32'(jobs_completed), 32'd1);
    tick(3);
    check_val("drain_hold", 32'(busy), 32'd1);
    ll_idle = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_gap_len", 32'(n), 32'(GAP + 1));
    check_val("cfg_hold", 32'({cfg_dma_base_addr, cfg_dma_num_bytes}), 32'h010020);
    check_val("single_done_cnt", 32'(done_cnt), 32'd1);

    // fill the FIFO while disabled, then overflow
    sched_enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      b  = 12'($urandom_range(1, 4095));
      nb = 12'($urandom_range(1, 4095));
      da = $urandom_range(1, 20);
      push_desc(b, nb, da, da, 1'b1);
    end
    check_val("fill_full", 32'(desc_full), 32'd1);
    check_val("fill_count", 32'(desc_count), 32'(DEPTH));
    push_desc(12'hABC, 12'h001, 0, 0, 1'b0);
    check_val("ovf_set", 32'(err_overflow), 32'd1);
    check_val("ovf_count", 32'(desc_count), 32'(DEPTH));
    pulse_clear();
    check_val("ovf_clear", 32'(err_overflow), 32'd0);
    // push while full on the same edge as the first pop: still dropped
    sched_enable = 1'b1;
    push_desc(12'hABD, 12'h002, 0, 0, 1'b0);
    check_val("ovf_pop_set", 32'(err_overflow), 32'd1);
    check_val("ovf_pop_count", 32'(desc_count), 32'(DEPTH - 1));
    wait_jobs(16'd5, "queue_jobs");
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    wait_idle("queue_idle");
    pulse_clear();

    // watchdog timeout, then recovery
    err_before = err_cnt;
    push_desc(12'h200, 12'h010, 0, TO, 1'b1);
    n = 0;
    while (job_err !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("to_pulse", 32'(job_err), 32'd1);
    check_val("to_sticky", 32'(err_timeout), 32'd1);
    check_val("to_jobs", 32'(jobs_completed), 32'd5);
    wait_idle("to_idle");
    check_val("to_err_cnt", 32'(err_cnt), 32'(err_before + 1));
    pulse_clear();
    check_val("to_clear", 32'(err_timeout), 32'd0);
    push_desc(12'h210, 12'h008, 5, 5, 1'b1);
    wait_jobs(16'd6, "to_recover");
    wait_idle("to_recover_idle");

    // zero-length descriptor is skipped
    sched_enable = 1'b0;
    err_before = err_cnt;
    push_desc(12'h000, 12'h000, 0, 0, 1'b0);
    push_desc(12'h100, 12'h004, 6, 6, 1'b1);
    sched_enable = 1'b1;
    wait_jobs(16'd7, "zero_next_job");
    check_val("zero_sticky", 32'(err_zero_len), 32'd1);
    check_val("zero_err_cnt", 32'(err_cnt), 32'(err_before + 1));
    wait_idle("zero_idle");
    pulse_clear();

    // done on the watchdog's last cycle: done wins
    err_before  = err_cnt;
    done_before = done_cnt;
    push_desc(12'h300, 12'h0FF, TO, TO, 1'b1);
    wait_jobs(16'd8, "tie_jobs");
    wait_idle("tie_idle");
    check_val("tie_no_err", 32'(err_cnt), 32'(err_before));
    check_val("tie_no_timeout", 32'(err_timeout), 32'd0);
    check_val("tie_done", 32'(done_cnt), 32'(done_before + 1));

    // disable during RUN: batch completes, nothing new pops
    push_desc(12'h400, 12'h010, 12, 12, 1'b1);
    wait_start("dis_start");
    sched_enable = 1'b0;
    push_desc(12'h410, 12'h020, 0, 0, 1'b1);
    wait_jobs(16'd9, "dis_jobs");
    wait_idle("dis_idle");
    tick(5);
    check_val("dis_count", 32'(desc_count), 32'd1);
    check_val("dis_no_start", 32'(start_rd), 32'd0);
    check_val("dis_pending", 32'(exp_q.size()), 32'd1);

    // reset during RUN
    sched_enable = 1'b1;
    wait_start("rst_run_start");
    push_desc(12'h420, 12'h001, 0, 0, 1'b0);
    tick(10);
    check_val("pre_rst_count", 32'(desc_count), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_start_rd", 32'(start_rd), 32'd0);
    check_val("mid_rst_count", 32'(desc_count), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_jobs", 32'(jobs_completed), 32'd0);
    tick(2);
    reset_n = 1'b1;
    stray_done = 1'b1;
    tick(3);
    stray_done = 1'b0;
    tick(20);
    check_val("stray_done_ignored", 32'(jobs_completed), 32'd0);
    check_val("post_rst_idle", 32'(busy), 32'd0);
    check_val("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rom_dma_batch_sched.md
# rom_dma_batch_sched

Batch scheduler that sequences the ROM DMA controller through a queue of DMA descriptors, each a base address and a byte count. It replaces the free-running config pulse with a host-loaded descriptor FIFO. For each descriptor it drives the controller's config/start inputs, waits for batch completion and for the linked-list engine to drain, then applies a programmable inter-batch gap. It sits between the host/config side and the ROM DMA controller, and adds a run-phase watchdog and error reporting.

## Interface
Parameters:
- ROM_ADDR_WIDTH, 12, width of ROM addresses and byte counts
- DESC_DEPTH, 4, descriptor FIFO entries (power of 2, ≥2)
- TIMEOUT_CYCLES, 4096, max RUN cycles before abort (≥2)
- GAP_CYCLES, 8, idle cycles between batches (≥1)

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- desc_push  in  1  write descriptor
- desc_base_addr  in  ROM_ADDR_WIDTH  descriptor base address
- desc_num_bytes  in  ROM_ADDR_WIDTH  descriptor byte count
- desc_full  out  1  FIFO full
- desc_count  out  $clog2(DESC_DEPTH+1)  FIFO occupancy
- sched_enable  in  1  allow new batches to launch
- start_rd  out  1  controller start, level
- cfg_ready  out  1  controller config valid, level
- cfg_dma_base_addr  out  ROM_ADDR_WIDTH  to controller
- cfg_dma_num_bytes  out  ROM_ADDR_WIDTH  to controller
- batch_dma_done  in  1  controller batch complete
- ll_idle  in  1  linked-list engine has no outstanding request/response
- clear_err  in  1  clears sticky errors
- busy  out  1  state ≠ IDLE
- job_done  out  1  1-cycle pulse on successful batch
- job_err  out  1  1-cycle pulse on timeout or zero-length skip
- err_timeout, err_zero_len, err_overflow  out  1 each  sticky errors
- jobs_completed  out  16  successful batch count, wraps at 0xFFFF→0

## Operation
- Reset values: all outputs and counters 0, FIFO empty, state IDLE.
- FIFO:
  - A push is accepted when `desc_full`=0 at that edge.
  - A push while full is dropped and sets `err_overflow`, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full leaves `desc_count` unchanged.
- FSM states: IDLE, LOAD, RUN, DRAIN, GAP.
- IDLE:
  - If `sched_enable` && `desc_count`≠0, pop the head entry.
  - num_bytes≠0: latch base/num into `cfg_dma_*` and go to LOAD.
  - num_bytes=0: pulse `job_err`, set `err_zero_len`, stay in IDLE (next entry may pop next cycle).
- LOAD: one cycle with `cfg_*` stable and `start_rd`/`cfg_ready`=0; then RUN.
- RUN:
  - `start_rd`=`cfg_ready`=1; watchdog counts from 0.
  - `batch_dma_done`=1 → deassert both at the next edge, pulse `job_done`, increment `jobs_completed`, go to DRAIN.
  - Else watchdog = TIMEOUT_CYCLES-1 → deassert, pulse `job_err`, set `err_timeout`, go to GAP (DRAIN skipped).
  - Done and timeout in the same cycle: done wins.
- DRAIN: wait for `ll_idle`=1, then go to GAP. No timeout.
- GAP: count GAP_CYCLES cycles, then IDLE.
- `cfg_dma_*` hold their last values outside LOAD/RUN.
- Deasserting `sched_enable` only blocks new pops; a batch in flight completes normally.
- `batch_dma_done` outside RUN is ignored.
- `clear_err` clears all sticky errors; a same-cycle set wins over clear.
- Reset mid-batch returns to IDLE, empties the FIFO and drops `start_rd` at that edge.

## Timing
- Pop decided at edge T (IDLE). LOAD during T+1; `start_rd`=1 from T+2.
- Done sampled high at edge D: `start_rd`=0 and `job_done`=1 during D+1.
- Timeout: `start_rd` is high for exactly TIMEOUT_CYCLES cycles.
- Minimum spacing between `start_rd` rising edges: 2 + run + 1 (DRAIN) + GAP_CYCLES cycles.
- A descriptor pushed into an empty FIFO at edge P is poppable at edge P+1 earliest.
- `job_done`/`job_err` are registered single-cycle pulses. `desc_full`/`desc_count` are registered.

## Test plan
- Single job: push (0x010, 0x020), enable; controller raises done 40 cycles after start → `cfg_*`=0x010/0x020 one cycle before `start_rd`; `start_rd` high 40 cycles; `job_done` pulse; `jobs_completed`=1; `busy` drops after `ll_idle`+8 cycles.
- Queue: push 4 descriptors with enable low → `desc_full`=1, `desc_count`=4; 5th push sets `err_overflow`; enable → 4 batches in FIFO order, `jobs_completed`=4.
- Timeout: TIMEOUT_CYCLES=16, never assert done → `start_rd` high 16 cycles, `job_err` pulse, `err_timeout`=1, `clear_err` clears it; next descriptor still runs.
- Zero length: queue (0x000,0) then (0x100,4) → `job_err` + `err_zero_len`, second job starts with `cfg_dma_base_addr`=0x100.
- Boundaries: done and timeout on the same cycle → `job_done` only. Disable during RUN → batch completes, no new pop. Reset during RUN → `start_rd`=0 next cycle, `desc_count`=0.
- Wrap: preload `jobs_completed`=0xFFFF via 65535 short jobs (or force) → next done gives 0x0000.
